// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared constants and elaboration-time helpers for the serial pattern detector.
//   MAX_PAT_LEN   : widest supported pattern
//   seq_det_next  : KMP transition (advance or fallback) for state s on bit x
//   seq_det_fail  : state to resume from after a full match when overlapping
// Patterns are passed zero-extended to MAX_PAT_LEN bits; bit len-1 is the
// first bit received.
// -----------------------------------------------------------------------------
package seq_det_pkg;

    localparam int MAX_PAT_LEN = 16;

    function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pattern, input int i);
        logic [MAX_PAT_LEN-1:0] t;
        t = pattern >> i;
        return t[0];
    endfunction

    // Longest proper prefix of the pattern that is a suffix of
    // (first s pattern bits, then x). Covers the advance case too, since the
    // full s+1 prefix is then itself such a suffix.
    function automatic int seq_det_next(input logic [MAX_PAT_LEN-1:0] pattern,
                                        input int len, input int s, input logic x);
        int   best;
        int   idx;
        logic ok;
        logic b;
        best = 0;
        for (int k = 1; k < MAX_PAT_LEN; k++) begin
            if (k < len && k <= s + 1) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_PAT_LEN; j++) begin
                    if (j < k) begin
                        idx = s + 1 - k + j;
                        b   = (idx == s) ? x : pat_bit(pattern, len - 1 - idx);
                        if (pat_bit(pattern, len - 1 - j) != b) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    function automatic int seq_det_fail(input logic [MAX_PAT_LEN-1:0] pattern, input int len);
        return seq_det_next(pattern, len, len - 1, pat_bit(pattern, 0));
    endfunction

endpackage

// File: rtl/seq_det_counter.sv
// -----------------------------------------------------------------------------
// seq_det_counter
// Saturating match counter with synchronous clear.
//   clk     : clock
//   reset   : asynchronous active-high reset
//   clr_i   : synchronous clear (wins over inc_i)
//   inc_i   : count one match
//   count_o : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module seq_det_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && count_q != '1)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
// Mealy serial pattern detector with a registered one-cycle match pulse.
// Optional feature macro: SEQ_DET_COUNT_EN builds the saturating match
// counter and the match_count port.
//   clk         : clock
//   reset       : asynchronous active-high reset
//   clr         : synchronous clear of match state, pulse and counter
//   x, x_valid  : serial bit and its qualifier
//   z           : match pulse, high the cycle after the final pattern bit
//   match_count : saturating match count (SEQ_DET_COUNT_EN only)
//   state       : matched-prefix length, debug
// -----------------------------------------------------------------------------
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       x,
    input  logic                       x_valid,
    output logic                       z,
`ifdef SEQ_DET_COUNT_EN
    output logic [CNT_W-1:0]           match_count,
`endif
    output logic [$clog2(PAT_LEN)-1:0] state
);

    localparam int SW = $clog2(PAT_LEN);
    localparam logic [MAX_PAT_LEN-1:0] PAT_EXT  = MAX_PAT_LEN'(PATTERN);
    localparam int                     FAIL_LEN = seq_det_fail(PAT_EXT, PAT_LEN);
    localparam logic [SW-1:0]          LAST     = SW'(PAT_LEN - 1);

    if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_len
        $fatal(1, "seq_detector: PAT_LEN %0d outside 2..%0d", PAT_LEN, MAX_PAT_LEN);
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
        $fatal(1, "seq_detector: CNT_W %0d outside 1..32", CNT_W);
    end

    // Transition table, one entry per (state, bit), fixed at elaboration.
    logic [PAT_LEN-1:0][1:0][SW-1:0] nxt_tbl;

    for (genvar g = 0; g < PAT_LEN; g++) begin : g_nxt
        localparam int N0 = seq_det_next(PAT_EXT, PAT_LEN, g, 1'b0);
        localparam int N1 = seq_det_next(PAT_EXT, PAT_LEN, g, 1'b1);
        assign nxt_tbl[g][0] = SW'(N0);
        assign nxt_tbl[g][1] = SW'(N1);
    end

    logic [SW-1:0] s_q, s_d;
    logic          z_q, z_d;
    logic          hit;

    // clr dominates x_valid: no match is reported on a clearing cycle.
    always_comb begin
        s_d = s_q;
        hit = 1'b0;
        if (clr) begin
            s_d = '0;
        end else if (x_valid) begin
            s_d = nxt_tbl[s_q][x];
            if (s_q == LAST && x == PATTERN[0]) begin
                hit = 1'b1;
                s_d = OVERLAP ? SW'(FAIL_LEN) : '0;
            end
        end
        z_d = hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q <= '0;
            z_q <= 1'b0;
        end else begin
            s_q <= s_d;
            z_q <= z_d;
        end
    end

    assign z     = z_q;
    assign state = s_q;

`ifdef SEQ_DET_COUNT_EN
    seq_det_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clr),
        .inc_i  (hit),
        .count_o(match_count)
    );
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Directed scoreboard bench: five detector instances with different
// configurations; the driver queues hand-computed expectations and a separate
// monitor compares them after each clock edge (or immediately for async checks).
module tb_seq_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] xv, xb, cl;

    logic       z0, z1, z2, z3, z4;
    logic [1:0] s0, s1, s4;
    logic       s2, s3;
`ifdef SEQ_DET_COUNT_EN
    logic [7:0] c0, c1, c2, c3;
    logic [1:0] c4;
`endif

    // d0: 1011 overlap   d1: 1011 no overlap   d2: 11 overlap
    // d3: 11 no overlap  d4: 1011 overlap, 2-bit counter
    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) d0 (
        .clk(clk), .reset(reset), .clr(cl[0]), .x(xb[0]), .x_valid(xv[0]), .z(z0),
`ifdef SEQ_DET_COUNT_EN
        .match_count(c0),
`endif
        .state(s0));
    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) d1 (
        .clk(clk), .reset(reset), .clr(cl[1]), .x(xb[1]), .x_valid(xv[1]), .z(z1),
`ifdef SEQ_DET_COUNT_EN
        .match_count(c1),
`endif
        .state(s1));
    seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(8)) d2 (
        .clk(clk), .reset(reset), .clr(cl[2]), .x(xb[2]), .x_valid(xv[2]), .z(z2),
`ifdef SEQ_DET_COUNT_EN
        .match_count(c2),
`endif
        .state(s2));
    seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b0), .CNT_W(8)) d3 (
        .clk(clk), .reset(reset), .clr(cl[3]), .x(xb[3]), .x_valid(xv[3]), .z(z3),
`ifdef SEQ_DET_COUNT_EN
        .match_count(c3),
`endif
        .state(s3));
    seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) d4 (
        .clk(clk), .reset(reset), .clr(cl[4]), .x(xb[4]), .x_valid(xv[4]), .z(z4),
`ifdef SEQ_DET_COUNT_EN
        .match_count(c4),
`endif
        .state(s4));

    typedef struct {
        int d;
        bit z;
        int s;
        int c;
    } exp_t;

    exp_t exp_q[$];
    exp_t snap_q[$];
    event snap_ev;
    exp_t m_e;
    int   errors = 0;
    int   checks = 0;

    function automatic int get_z(input int d);
        case (d)
            0: return int'(z0);
            1: return int'(z1);
            2: return int'(z2);
            3: return int'(z3);
            4: return int'(z4);
            default: return -1;
        endcase
    endfunction

    function automatic int get_s(input int d);
        case (d)
            0: return int'(s0);
            1: return int'(s1);
            2: return int'(s2);
            3: return int'(s3);
            4: return int'(s4);
            default: return -1;
        endcase
    endfunction

`ifdef SEQ_DET_COUNT_EN
    function automatic int get_c(input int d);
        case (d)
            0: return int'(c0);
            1: return int'(c1);
            2: return int'(c2);
            3: return int'(c3);
            4: return int'(c4);
            default: return -1;
        endcase
    endfunction
`endif

    task automatic cmp(input string tag, input int d, input string what, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d %s: got %0d, want %0d (t=%0t)", tag, d, what, act, exp, $time);
        end
    endtask

    task automatic check_entry(input string tag, input exp_t e);
        if (e.d < 0) begin
            cmp(tag, e.d, "pending_expectations", exp_q.size(), 0);
        end else begin
            cmp(tag, e.d, "z", get_z(e.d), int'(e.z));
            cmp(tag, e.d, "state", get_s(e.d), e.s);
`ifdef SEQ_DET_COUNT_EN
            cmp(tag, e.d, "match_count", get_c(e.d), e.c);
`endif
        end
    endtask

    // Monitor: the only process that touches the counters.
    initial begin
        forever begin
            @(posedge clk or snap_ev);
            if (snap_q.size() > 0) begin
                while (snap_q.size() > 0) begin
                    m_e = snap_q.pop_front();
                    check_entry("snap", m_e);
                end
            end else begin
                #1;
                while (exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    check_entry("step", m_e);
                end
            end
        end
    end

    // Drive one cycle on instance d and queue the state expected after the edge.
    task automatic vec(input int d, input bit v, input bit b, input bit c,
                       input bit ez, input int es, input int ec);
        @(negedge clk);
        xv = '0; xb = '0; cl = '0;
        xv[d] = v; xb[d] = b; cl[d] = c;
        exp_q.push_back('{d, ez, es, ec});
    endtask

    task automatic idle();
        @(negedge clk);
        xv = '0; xb = '0; cl = '0;
    endtask

    task automatic snap(input int d, input bit ez, input int es, input int ec);
        snap_q.push_back('{d, ez, es, ec});
    endtask

    initial begin
        reset = 1'b1;
        xv = '0; xb = '0; cl = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) snap(i, 1'b0, 0, 0);
        -> snap_ev;
        #1;
        reset = 1'b0;

        // 1011 overlapping: matches after bits 4 and 7
        vec(0, 1, 1, 0, 0, 1, 0);
        vec(0, 1, 0, 0, 0, 2, 0);
        vec(0, 1, 1, 0, 0, 3, 0);
        vec(0, 1, 1, 0, 1, 1, 1);
        vec(0, 1, 0, 0, 0, 2, 1);
        vec(0, 1, 1, 0, 0, 3, 1);
        vec(0, 1, 1, 0, 1, 1, 2);

        // 1011 non-overlapping: single match after bit 4
        vec(1, 1, 1, 0, 0, 1, 0);
        vec(1, 1, 0, 0, 0, 2, 0);
        vec(1, 1, 1, 0, 0, 3, 0);
        vec(1, 1, 1, 0, 1, 0, 1);
        vec(1, 1, 0, 0, 0, 0, 1);
        vec(1, 1, 1, 0, 0, 1, 1);
        vec(1, 1, 1, 0, 0, 1, 1);

        // 11 overlapping: three back-to-back pulses
        vec(2, 1, 1, 0, 0, 1, 0);
        vec(2, 1, 1, 0, 1, 1, 1);
        vec(2, 1, 1, 0, 1, 1, 2);
        vec(2, 1, 1, 0, 1, 1, 3);

        // 11 non-overlapping: pulses after bits 2 and 4
        vec(3, 1, 1, 0, 0, 1, 0);
        vec(3, 1, 1, 0, 1, 0, 1);
        vec(3, 1, 1, 0, 0, 1, 1);
        vec(3, 1, 1, 0, 1, 0, 2);

        // clr, then 1,0,1, a five-cycle valid gap, then the final 1
        vec(0, 0, 0, 1, 0, 0, 0);
        vec(0, 1, 1, 0, 0, 1, 0);
        vec(0, 1, 0, 0, 0, 2, 0);
        vec(0, 1, 1, 0, 0, 3, 0);
        for (int i = 0; i < 5; i++) vec(0, 0, 1, 0, 0, 3, 0);
        vec(0, 1, 1, 0, 1, 1, 1);

        // Counter saturation on a 2-bit counter, then clr together with valid
        vec(4, 1, 1, 0, 0, 1, 0);
        vec(4, 1, 0, 0, 0, 2, 0);
        vec(4, 1, 1, 0, 0, 3, 0);
        vec(4, 1, 1, 0, 1, 1, 1);
        for (int m = 2; m <= 5; m++) begin
            vec(4, 1, 0, 0, 0, 2, (m - 1 > 3) ? 3 : m - 1);
            vec(4, 1, 1, 0, 0, 3, (m - 1 > 3) ? 3 : m - 1);
            vec(4, 1, 1, 0, 1, 1, (m > 3) ? 3 : m);
        end
        vec(4, 1, 1, 1, 0, 0, 0);

        // Mid-pattern async reset on d0 (at state 1, count 1): 1,0,1 -> state 3
        vec(0, 1, 1, 0, 0, 1, 1);
        vec(0, 1, 0, 0, 0, 2, 1);
        vec(0, 1, 1, 0, 0, 3, 1);
        idle();
        #2;
        reset = 1'b1;
        #1;
        snap(0, 1'b0, 0, 0);
        -> snap_ev;
        #1;
        reset = 1'b0;
        // A lone 1 after reset must restart the search, not complete a match.
        vec(0, 1, 1, 0, 0, 1, 0);
        idle();

        repeat (2) @(negedge clk);
        snap(-1, 1'b0, 0, 0);
        -> snap_ev;
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised Mealy serial pattern detector. It is the successor to the fixed four-state 1011 detector, generalised to any pattern up to 16 bits, with an input-valid qualifier, a selectable overlap mode, a synchronous clear, and an optional saturating match counter. It sits on a one-bit serial data path and produces a registered one-cycle match pulse.

## Interface
- PAT_LEN, 4: pattern length in bits, legal range 2..16.
- PATTERN, 4'b1011: pattern, PAT_LEN bits wide. PATTERN[PAT_LEN-1] is the first bit received.
- OVERLAP, 1: 1 means a matched pattern's suffix may start the next match; 0 means the search restarts after every match.
- CNT_W, 8: match counter width, legal range 1..32.
- clk  input  1: single clock; all state changes on its rising edge.
- reset  input  1: asynchronous, active-high reset.
- clr  input  1: synchronous clear of the match state and the counter.
- x  input  1: serial data bit.
- x_valid  input  1: x is sampled only when x_valid=1.
- z  output  1: registered match pulse.
- match_count  output  CNT_W: saturating count of matches (present only with SEQ_DET_COUNT_EN).
- state  output  $clog2(PAT_LEN): current matched-prefix length, for debug.

## Operation
- State S = number of pattern bits currently matched, 0..PAT_LEN-1. Reset and clr force S=0.
- x_valid=1 and x equals the expected bit PATTERN[PAT_LEN-1-S]:
  - If S<PAT_LEN-1: S <= S+1.
  - If S=PAT_LEN-1: this is a match.
- x_valid=1 and x mismatches: S <= KMP fallback, i.e. the longest proper prefix of the pattern that is a suffix of (matched bits followed by x). The fallback may be 0.
- Next state on a match:
  - OVERLAP=1: S <= failure length of the full pattern. For 1011 this is 1.
  - OVERLAP=0: S <= 0.
- x_valid=0: S holds.
- The transition table is computed at elaboration from PATTERN. No runtime pattern load.
- z <= x_valid && (S==PAT_LEN-1) && (x==PATTERN[0]). z is cleared by reset and by clr.
- clr together with x_valid: clr wins. No match is reported and S=0.
- Parameter checks: PAT_LEN outside 2..16 or CNT_W outside 1..32 stops elaboration with $fatal.

## Timing
- Match latency is 1 cycle. z is high for exactly the one clk cycle after the edge that samples the final pattern bit.
- Back-to-back matches produce consecutive z pulses. This needs OVERLAP=1 and a self-overlapping pattern, e.g. 11 on stream 1,1,1.
- Reset values: z=0, state=0, match_count=0.
- Asserting reset mid-pattern discards the partial match. The first valid bit after reset release is treated as bit 0 of a new search.
- match_count updates on the same edge as z rises, so it is visible in the same cycle z=1.

## Configuration
- SEQ_DET_COUNT_EN defined:
  - match_count port and counter are built.
  - The counter increments on each match and saturates at 2^CNT_W-1; it does not wrap.
  - clr and reset zero the counter.
- SEQ_DET_COUNT_EN undefined: the match_count port and counter logic are absent. All other behaviour is identical.

## Structure
- Package seq_det_pkg contains:
  - the constant function seq_det_next(pattern, len, s, x), which returns the fallback or advance state;
  - the constant function seq_det_fail(pattern, len), which returns the full-match failure length;
  - localparam MAX_PAT_LEN=16.
- Sub-module seq_det_counter holds the saturating counter with clr. It is instantiated only under SEQ_DET_COUNT_EN.
- The top module holds the state register, the z register, and the elaborated next-state function.

## Test plan
- PATTERN=1011, OVERLAP=1, stream 1,0,1,1,0,1,1 -> z pulses after bit 4 and after bit 7, and match_count=2.
- Same stream with OVERLAP=0 -> z pulses once, after bit 4 only, and match_count=1.
- PATTERN=11, OVERLAP=1, stream 1,1,1,1 -> z high for 3 consecutive cycles; with OVERLAP=0, z pulses after bits 2 and 4.
- Stream 1,0,1 then x_valid=0 for 5 cycles, then 1 -> state holds at 3 during the gap, and z pulses once after the final 1.
- Assert reset asynchronously mid-cycle after bits 1,0,1 -> z, state and match_count go to 0 immediately, and a following single 1 gives no match.
- CNT_W=2 with 5 matches -> match_count saturates at 3. clr then gives match_count=0 and state=0 on the next edge.
